// File: rtl/cpu_clk_enable_ctrl_if.sv
// Control/status bundle between the pipeline clock-enable controller and its debug/clock sources.
// master drives the requests and divided clock; slave (the controller) returns enable and status.
interface cpu_clk_enable_ctrl_if #(
    parameter int unsigned CW = 32
);
    logic          clk_d;
    logic          run;
    logic          step_btn;
    logic          halt_req;
    logic          bp_en;
    logic [CW-1:0] bp_cycle;
    logic          cpu_en;
    logic [CW-1:0] cycle_count;
    logic          halted;
    logic [1:0]    state;

    modport master (
        output clk_d, run, step_btn, halt_req, bp_en, bp_cycle,
        input  cpu_en, cycle_count, halted, state
    );

    modport slave (
        input  clk_d, run, step_btn, halt_req, bp_en, bp_cycle,
        output cpu_en, cycle_count, halted, state
    );
endinterface

// File: rtl/cpu_clk_enable_ctrl.sv
// Turns the divided clock into a one-clk pipeline enable with run/step/halt/breakpoint control.
// Keeps a wrapping count of issued enables for debug display.
module cpu_clk_enable_ctrl #(
    parameter int unsigned CW         = 32,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_clk_enable_ctrl_if.slave  bus
);
    localparam int unsigned   DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    logic          r_clkd_s1, r_clkd_s2, r_clkd_prev;
    logic          r_btn_s1, r_btn_s2;
    logic          r_deb;
    logic [DW-1:0] r_deb_cnt;
    logic          r_step_pulse;
    state_t        r_state;
    logic          r_cpu_en;
    logic          r_halted;
    logic [CW-1:0] r_cycle_count;
    logic          w_tick;

    assign w_tick = r_clkd_s2 & ~r_clkd_prev;

    // Synchronizers, tick edge detect and step button debouncer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkd_s1    <= 1'b0;
            r_clkd_s2    <= 1'b0;
            r_clkd_prev  <= 1'b0;
            r_btn_s1     <= 1'b0;
            r_btn_s2     <= 1'b0;
            r_deb        <= 1'b0;
            r_deb_cnt    <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_clkd_s1    <= bus.clk_d;
            r_clkd_s2    <= r_clkd_s1;
            r_clkd_prev  <= r_clkd_s2;
            r_btn_s1     <= bus.step_btn;
            r_btn_s2     <= r_btn_s1;
            r_step_pulse <= 1'b0;
            if (r_btn_s2 != r_deb) begin
                if (r_deb_cnt == DEB_LAST) begin
                    r_deb        <= ~r_deb;
                    r_deb_cnt    <= '0;
                    r_step_pulse <= ~r_deb;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_ONE;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // Halted is registered alongside every state change rather than decoded from r_state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_HALT;
            r_cpu_en      <= 1'b0;
            r_halted      <= 1'b1;
            r_cycle_count <= '0;
        end else begin
            r_cpu_en <= 1'b0;
            if (bus.halt_req) begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
            end else begin
                case (r_state)
                    ST_HALT: begin
                        if (bus.run) begin
                            r_state  <= ST_RUN;
                            r_halted <= 1'b0;
                        end else if (r_step_pulse) begin
                            r_state  <= ST_STEP;
                            r_halted <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.run) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (w_tick) begin
                            if (bus.bp_en && (r_cycle_count == bus.bp_cycle)) begin
                                r_state  <= ST_BREAK;
                                r_halted <= 1'b1;
                            end else begin
                                r_cpu_en      <= 1'b1;
                                r_cycle_count <= r_cycle_count + CNT_ONE;
                            end
                        end
                    end
                    ST_STEP: begin
                        if (w_tick) begin
                            r_cpu_en      <= 1'b1;
                            r_cycle_count <= r_cycle_count + CNT_ONE;
                            r_state       <= ST_HALT;
                            r_halted      <= 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (!bus.run) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (r_step_pulse) begin
                            r_state  <= ST_STEP;
                            r_halted <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.cpu_en      = r_cpu_en;
    assign bus.cycle_count = r_cycle_count;
    assign bus.halted      = r_halted;
    assign bus.state       = r_state;
endmodule
